// File: rtl/upconverter_pkg.sv
// rtl/upconverter_pkg.sv - shared constants, state type, LUT builder and output rounding
package upconverter_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_PHASE_W  = 32;
  localparam int DEF_LUT_BITS = 10;
  localparam int DEF_INTERP   = 4;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic {IDLE, RUN} state_t;

  // One entry of the full-wave table: round(A * cos/sin(2*pi*k/2^lut_bits)), A = 2^(width-1)-1.
  // Called only with constant arguments, so the table folds to a ROM.
  function automatic longint lut_value(input int k, input int lut_bits, input int width,
                                       input bit is_sin);
    real ang;
    real amp;
    real v;
    ang = 2.0 * PI * real'(k) / real'(longint'(1) << lut_bits);
    amp = real'((longint'(1) << (width - 1)) - 1);
    v   = amp * (is_sin ? $sin(ang) : $cos(ang));
    return longint'(v);
  endfunction

  // Round half-up at bit w-1, arithmetic shift down by w-1, then clamp to a signed w-bit range.
  function automatic longint sat_round(input longint acc, input int w);
    longint hi;
    longint lo;
    longint r;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    r  = (acc + (longint'(1) <<< (w - 2))) >>> (w - 1);
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/upconverter_nco.sv
// rtl/upconverter_nco.sv - free-running dual-phase NCO with registered sin/cos lookup
module upconverter_nco
  import upconverter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PHASE_W  = DEF_PHASE_W,
  parameter int LUT_BITS = DEF_LUT_BITS
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [PHASE_W-1:0]        i_phase_inc,
  input  logic                      i_phase_inc_valid,
  output logic signed [WIDTH-1:0]   cos0,
  output logic signed [WIDTH-1:0]   sin0,
  output logic signed [WIDTH-1:0]   cos1,
  output logic signed [WIDTH-1:0]   sin1
);

  localparam int LUT_SIZE = 2 ** LUT_BITS;

  logic signed [WIDTH-1:0] cos_rom [LUT_SIZE];
  logic signed [WIDTH-1:0] sin_rom [LUT_SIZE];
  logic [PHASE_W-1:0]      phase;
  logic [PHASE_W-1:0]      phase_inc;
  logic [PHASE_W-1:0]      phase1;
  logic [LUT_BITS-1:0]     idx0;
  logic [LUT_BITS-1:0]     idx1;

  // ROM contents depend only on parameters
  always_comb begin
    for (int k = 0; k < LUT_SIZE; k++) begin
      cos_rom[k] = WIDTH'(lut_value(k, LUT_BITS, WIDTH, 1'b0));
      sin_rom[k] = WIDTH'(lut_value(k, LUT_BITS, WIDTH, 1'b1));
    end
  end

  // Second real sample of the pair sits one increment ahead; LUT index is the truncated phase MSBs
  assign phase1 = phase + phase_inc;
  assign idx0   = phase[PHASE_W-1 -: LUT_BITS];
  assign idx1   = phase1[PHASE_W-1 -: LUT_BITS];

  // Accumulator steps two real samples per cycle; a new increment applies from the next step
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      phase     <= '0;
      phase_inc <= '0;
    end else begin
      phase <= phase + {phase_inc[PHASE_W-2:0], 1'b0};
      if (i_phase_inc_valid) begin
        phase_inc <= i_phase_inc;
      end
    end
  end

  // S1: registered LUT read for both slot phases
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cos0 <= '0;
      sin0 <= '0;
      cos1 <= '0;
      sin1 <= '0;
    end else begin
      cos0 <= cos_rom[idx0];
      sin0 <= sin_rom[idx0];
      cos1 <= cos_rom[idx1];
      sin1 <= sin_rom[idx1];
    end
  end

endmodule

// File: rtl/upconverter.sv
// rtl/upconverter.sv - sample-hold interpolator and NCO mixer producing a two-sample real IF stream
module upconverter
  import upconverter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PHASE_W  = DEF_PHASE_W,
  parameter int LUT_BITS = DEF_LUT_BITS,
  parameter int INTERP   = DEF_INTERP
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic signed [WIDTH-1:0]  i_inph_data,
  input  logic signed [WIDTH-1:0]  i_quad_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [PHASE_W-1:0]       i_phase_inc,
  input  logic                     i_phase_inc_valid,
  output logic signed [WIDTH-1:0]  o_inph_data,
  output logic signed [WIDTH-1:0]  o_inph_delay_data,
  output logic                     o_valid
);

  localparam int CNT_W = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(INTERP - 1);

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         count, count_nxt;
  logic                     accept, load;
  logic signed [WIDTH-1:0]  hold_i, hold_q;
  logic signed [WIDTH-1:0]  cos0, sin0, cos1, sin1;
  logic                     s1_valid, s2_valid;
  logic signed [WIDTH-1:0]  s1_i, s1_q;
  logic signed [2*WIDTH-1:0] p_ic0, p_qs0, p_ic1, p_qs1;
  logic signed [2*WIDTH:0]  sum0, sum1;

  assign o_ready = ~i_reset & ((state == IDLE) | (count == LAST));
  assign accept  = i_valid & o_ready;

  upconverter_nco #(
    .WIDTH    (WIDTH),
    .PHASE_W  (PHASE_W),
    .LUT_BITS (LUT_BITS)
  ) u_nco (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_phase_inc       (i_phase_inc),
    .i_phase_inc_valid (i_phase_inc_valid),
    .cos0              (cos0),
    .sin0              (sin0),
    .cos1              (cos1),
    .sin1              (sin1)
  );

  // Next state: each RUN cycle is one output slot; the last slot either reloads or underflows to IDLE
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
          count_nxt = '0;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (count == LAST) begin
          count_nxt = '0;
          if (accept) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, slot counter and hold registers; hold regs keep their value across underflow
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      count  <= '0;
      hold_i <= '0;
      hold_q <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (load) begin
        hold_i <= i_inph_data;
        hold_q <= i_quad_data;
      end
    end
  end

  // S1/S2: align held I/Q with the LUT read, then form the four products
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_i     <= '0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      p_ic0    <= '0;
      p_qs0    <= '0;
      p_ic1    <= '0;
      p_qs1    <= '0;
    end else begin
      s1_valid <= (state == RUN);
      s1_i     <= hold_i;
      s1_q     <= hold_q;
      s2_valid <= s1_valid;
      p_ic0    <= (2*WIDTH)'(s1_i) * (2*WIDTH)'(cos0);
      p_qs0    <= (2*WIDTH)'(s1_q) * (2*WIDTH)'(sin0);
      p_ic1    <= (2*WIDTH)'(s1_i) * (2*WIDTH)'(cos1);
      p_qs1    <= (2*WIDTH)'(s1_q) * (2*WIDTH)'(sin1);
    end
  end

  assign sum0 = (2*WIDTH+1)'(p_ic0) - (2*WIDTH+1)'(p_qs0);
  assign sum1 = (2*WIDTH+1)'(p_ic1) - (2*WIDTH+1)'(p_qs1);

  // S3: round, saturate and register the output pair; outputs hold when no pair is valid
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_valid           <= 1'b0;
      o_inph_data       <= '0;
      o_inph_delay_data <= '0;
    end else begin
      o_valid <= s2_valid;
      if (s2_valid) begin
        o_inph_data       <= WIDTH'(sat_round(longint'(sum0), WIDTH));
        o_inph_delay_data <= WIDTH'(sat_round(longint'(sum1), WIDTH));
      end
    end
  end

endmodule
